// File: rtl/game_controller_if.sv
// Signal bundle between the game turn sequencer and its environment
// (buttons, time base, feedback block, history store).
interface game_controller_if;
  logic       btn_start;
  logic       btn_submit;
  logic       btn_mode;
  logic       tick;
  logic       fb_valid;
  logic [2:0] fb_exact;
  logic       mode;
  logic       store;
  logic       hist_clr;
  logic [3:0] turn;
  logic       busy;
  logic       win;
  logic       lose;
  logic       fb_err;

  modport master (
    output btn_start, btn_submit, btn_mode, tick, fb_valid, fb_exact,
    input  mode, store, hist_clr, turn, busy, win, lose, fb_err
  );

  modport slave (
    input  btn_start, btn_submit, btn_mode, tick, fb_valid, fb_exact,
    output mode, store, hist_clr, turn, busy, win, lose, fb_err
  );
endinterface

// File: rtl/game_controller.sv
// Turn sequencer for the code-breaking game: game FSM, history strobes, win/lose decision.
// Optional per-turn auto-submit timer is built when TURN_TIMER_EN is defined.
module game_controller #(
  parameter int NUM_TURNS  = 8,
  parameter int NUM_PEGS   = 4,
  parameter int FB_TIMEOUT = 15,
  parameter int TURN_TICKS = 30
) (
  input logic              clk,
  input logic              reset,
  game_controller_if.slave gc
);

  localparam int FCW = $clog2(FB_TIMEOUT + 1);
  localparam logic [3:0]     MAX_TURN = 4'(NUM_TURNS);
  localparam logic [2:0]     SOLVED   = 3'(NUM_PEGS);
  localparam logic [FCW-1:0] FB_LAST  = FCW'(FB_TIMEOUT - 1);
  localparam logic [FCW-1:0] FB_SAT   = FCW'(FB_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_GUESS, S_STORE, S_WAIT_FB, S_HIST, S_WIN, S_LOSE
  } state_t;

  state_t         state_r, state_next_s;
  logic [3:0]     turn_r;
  logic [FCW-1:0] fb_cnt_r;
  logic           mode_r, store_r, hist_clr_r, busy_r, win_r, lose_r, fb_err_r;
  logic           timeout_s, submit_s, timer_fire_s, timer_hist_s;

`ifdef TURN_TIMER_EN
  localparam int TW = $clog2(TURN_TICKS + 1);
  logic [TW-1:0] timer_r;
  logic          timer_load_s;

  // Expiry in GUESS (including a timer already at 0 after leaving HIST) acts as a submit.
  assign timer_fire_s = (timer_r == TW'(0)) || (gc.tick && timer_r == TW'(1));
  assign timer_hist_s = gc.tick && (timer_r == TW'(1));
  assign timer_load_s = gc.btn_start ||
                        (state_next_s == S_GUESS && state_r != S_GUESS && state_r != S_HIST);

  // Per-turn countdown; HIST returns keep the remaining time.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= '0;
    end else if (timer_load_s) begin
      timer_r <= TW'(TURN_TICKS);
    end else if (gc.tick && timer_r != TW'(0) && (state_r == S_GUESS || state_r == S_HIST)) begin
      timer_r <= timer_r - TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end
`else
  logic unused_timer_s;
  assign timer_fire_s   = 1'b0;
  assign timer_hist_s   = 1'b0;
  assign unused_timer_s = ^{gc.tick, (TURN_TICKS > 32'sd0)};
`endif

  assign submit_s = gc.btn_submit || timer_fire_s;

  // Next-state decode; start overrides everything, including a pending feedback result.
  always_comb begin
    state_next_s = state_r;
    timeout_s    = 1'b0;
    if (gc.btn_start) begin
      state_next_s = S_GUESS;
    end else begin
      case (state_r)
        S_IDLE:  state_next_s = S_IDLE;
        S_GUESS: begin
          if (submit_s && turn_r < MAX_TURN) begin
            state_next_s = S_STORE;
          end else if (!submit_s && gc.btn_mode && turn_r != 4'd0) begin
            state_next_s = S_HIST;
          end else begin
            state_next_s = S_GUESS;
          end
        end
        S_STORE: state_next_s = S_WAIT_FB;
        S_WAIT_FB: begin
          if (gc.fb_valid) begin
            if (gc.fb_exact == SOLVED) begin
              state_next_s = S_WIN;
            end else if (turn_r == MAX_TURN) begin
              state_next_s = S_LOSE;
            end else begin
              state_next_s = S_GUESS;
            end
          end else if (fb_cnt_r == FB_LAST) begin
            timeout_s    = 1'b1;
            state_next_s = (turn_r == MAX_TURN) ? S_LOSE : S_GUESS;
          end else begin
            state_next_s = S_WAIT_FB;
          end
        end
        S_HIST: begin
          if (gc.btn_mode || timer_hist_s) begin
            state_next_s = S_GUESS;
          end else begin
            state_next_s = S_HIST;
          end
        end
        S_WIN:   state_next_s = S_WIN;
        S_LOSE:  state_next_s = S_LOSE;
        default: state_next_s = S_IDLE;
      endcase
    end
  end

  // State, counters and outputs; outputs decode the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      turn_r     <= '0;
      fb_cnt_r   <= '0;
      mode_r     <= 1'b0;
      store_r    <= 1'b0;
      hist_clr_r <= 1'b0;
      busy_r     <= 1'b0;
      win_r      <= 1'b0;
      lose_r     <= 1'b0;
      fb_err_r   <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      mode_r     <= (state_next_s == S_HIST) || (state_next_s == S_WIN) || (state_next_s == S_LOSE);
      store_r    <= (state_next_s == S_STORE);
      busy_r     <= (state_next_s == S_STORE) || (state_next_s == S_WAIT_FB);
      win_r      <= (state_next_s == S_WIN);
      lose_r     <= (state_next_s == S_LOSE);
      hist_clr_r <= gc.btn_start;

      if (gc.btn_start) begin
        turn_r <= '0;
      end else if (state_r == S_STORE && turn_r < MAX_TURN) begin
        turn_r <= turn_r + 4'd1;
      end else begin
        turn_r <= turn_r;
      end

      if (gc.btn_start || state_r == S_STORE) begin
        fb_cnt_r <= '0;
      end else if (state_r == S_WAIT_FB && fb_cnt_r != FB_SAT) begin
        fb_cnt_r <= fb_cnt_r + FCW'(1);
      end else begin
        fb_cnt_r <= fb_cnt_r;
      end

      if (gc.btn_start) begin
        fb_err_r <= 1'b0;
      end else if (timeout_s) begin
        fb_err_r <= 1'b1;
      end else begin
        fb_err_r <= fb_err_r;
      end
    end
  end

  assign gc.mode     = mode_r;
  assign gc.store    = store_r;
  assign gc.hist_clr = hist_clr_r;
  assign gc.turn     = turn_r;
  assign gc.busy     = busy_r;
  assign gc.win      = win_r;
  assign gc.lose     = lose_r;
  assign gc.fb_err   = fb_err_r;

endmodule

// File: tb/tb_game_controller.sv
// Directed self-checking bench for game_controller (TURN_TICKS overridden to 3).
module tb_game_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   store_cnt;

  game_controller_if gc ();

  game_controller #(
    .NUM_TURNS (8),
    .NUM_PEGS  (4),
    .FB_TIMEOUT(15),
    .TURN_TICKS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .gc   (gc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store pulses counted just after each edge, away from the task sampling points.
  always @(posedge clk) begin
    #1;
    if (gc.store === 1'b1) store_cnt = store_cnt + 1;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if ({gc.mode, gc.store, gc.hist_clr, gc.turn, gc.busy, gc.win, gc.lose, gc.fb_err} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {gc.mode, gc.store, gc.hist_clr, gc.turn, gc.busy, gc.win, gc.lose, gc.fb_err});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_start();
    gc.btn_start = 1'b1;
    cyc();
    gc.btn_start = 1'b0;
    n_checks++;
    if ({gc.hist_clr, gc.mode, gc.turn} !== {1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL start_pulse: hist_clr=%b mode=%b turn=%0d expected 1,0,0", gc.hist_clr, gc.mode, gc.turn);
    end
    cyc();
    n_checks++;
    if (gc.hist_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL hist_clr_width: got %b expected 0", gc.hist_clr);
    end
    gc.btn_mode = 1'b1;
    cyc();
    gc.btn_mode = 1'b0;
    n_checks++;
    if (gc.mode !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_turn0_ignored: got %b expected 0", gc.mode);
    end
  endtask

  task automatic test_win();
    int s0;
    s0 = store_cnt;
    gc.btn_submit = 1'b1;
    cyc();
    gc.btn_submit = 1'b0;
    n_checks++;
    if ({gc.store, gc.busy, gc.turn} !== {1'b1, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL store_cycle: store=%b busy=%b turn=%0d expected 1,1,0", gc.store, gc.busy, gc.turn);
    end
    cyc();
    gc.fb_valid = 1'b1;
    gc.fb_exact = 3'd4;
    n_checks++;
    if ({gc.store, gc.busy, gc.turn} !== {1'b0, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL wait_fb_cycle: store=%b busy=%b turn=%0d expected 0,1,1", gc.store, gc.busy, gc.turn);
    end
    cyc();
    gc.fb_valid = 1'b0;
    n_checks++;
    if ({gc.win, gc.mode, gc.busy, gc.lose, gc.turn} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL win: win=%b mode=%b busy=%b lose=%b turn=%0d expected 1,1,0,0,1",
               gc.win, gc.mode, gc.busy, gc.lose, gc.turn);
    end
    gc.btn_submit = 1'b1;
    cyc();
    gc.btn_submit = 1'b0;
    cyc();
    n_checks++;
    if ((store_cnt - s0) !== 1 || gc.win !== 1'b1) begin
      n_fail++;
      $display("FAIL win_terminal: stores=%0d win=%b expected 1,1", store_cnt - s0, gc.win);
    end
  endtask

  task automatic test_lose();
    int s0;
    gc.btn_start = 1'b1;
    cyc();
    gc.btn_start = 1'b0;
    s0 = store_cnt;
    for (int i = 0; i < 8; i++) begin
      gc.btn_submit = 1'b1;
      cyc();
      gc.btn_submit = 1'b0;
      cyc();
      gc.fb_valid = 1'b1;
      gc.fb_exact = (i == 5) ? 3'd5 : 3'd2;
      cyc();
      gc.fb_valid = 1'b0;
      if (i == 3) begin
        n_checks++;
        if ({gc.lose, gc.mode, gc.turn} !== {1'b0, 1'b0, 4'd4}) begin
          n_fail++;
          $display("FAIL mid_game: lose=%b mode=%b turn=%0d expected 0,0,4", gc.lose, gc.mode, gc.turn);
        end
      end
    end
    n_checks++;
    if ({gc.lose, gc.win, gc.mode, gc.turn} !== {1'b1, 1'b0, 1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL lose: lose=%b win=%b mode=%b turn=%0d expected 1,0,1,8", gc.lose, gc.win, gc.mode, gc.turn);
    end
    gc.btn_submit = 1'b1;
    cyc();
    gc.btn_submit = 1'b0;
    cyc();
    n_checks++;
    if ((store_cnt - s0) !== 8 || gc.turn !== 4'd8) begin
      n_fail++;
      $display("FAIL store_count: stores=%0d turn=%0d expected 8,8", store_cnt - s0, gc.turn);
    end
  endtask

  task automatic test_timeout();
    int n;
    gc.btn_start = 1'b1;
    cyc();
    gc.btn_start = 1'b0;
    gc.btn_submit = 1'b1;
    cyc();
    gc.btn_submit = 1'b0;
    n = 0;
    while (gc.busy === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    n_checks++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL timeout_busy_cycles: got %0d expected 16", n);
    end
    n_checks++;
    if ({gc.fb_err, gc.mode, gc.lose, gc.turn} !== {1'b1, 1'b0, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL timeout_state: fb_err=%b mode=%b lose=%b turn=%0d expected 1,0,0,1",
               gc.fb_err, gc.mode, gc.lose, gc.turn);
    end
    gc.btn_submit = 1'b1;
    gc.btn_mode   = 1'b1;
    cyc();
    gc.btn_submit = 1'b0;
    gc.btn_mode   = 1'b0;
    n_checks++;
    if ({gc.store, gc.mode} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL submit_beats_mode: store=%b mode=%b expected 1,0", gc.store, gc.mode);
    end
    cyc();
    gc.fb_valid = 1'b1;
    gc.fb_exact = 3'd1;
    cyc();
    gc.fb_valid = 1'b0;
    n_checks++;
    if ({gc.fb_err, gc.turn, gc.busy} !== {1'b1, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL fb_err_sticky: fb_err=%b turn=%0d busy=%b expected 1,2,0", gc.fb_err, gc.turn, gc.busy);
    end
  endtask

  task automatic test_hist();
    int s0;
    s0 = store_cnt;
    gc.btn_mode = 1'b1;
    cyc();
    gc.btn_mode = 1'b0;
    n_checks++;
    if (gc.mode !== 1'b1) begin
      n_fail++;
      $display("FAIL hist_enter: mode=%b expected 1", gc.mode);
    end
    gc.btn_submit = 1'b1;
    cyc();
    gc.btn_submit = 1'b0;
    gc.btn_mode = 1'b1;
    cyc();
    gc.btn_mode = 1'b0;
    n_checks++;
    if ({gc.mode, gc.turn} !== {1'b0, 4'd2} || (store_cnt - s0) !== 0) begin
      n_fail++;
      $display("FAIL hist_exit: mode=%b turn=%0d stores=%0d expected 0,2,0", gc.mode, gc.turn, store_cnt - s0);
    end
  endtask

  task automatic test_restart();
    gc.btn_submit = 1'b1;
    cyc();
    gc.btn_submit = 1'b0;
    cyc();
    gc.btn_start = 1'b1;
    cyc();
    gc.btn_start = 1'b0;
    n_checks++;
    if ({gc.hist_clr, gc.turn, gc.busy, gc.fb_err} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL restart: hist_clr=%b turn=%0d busy=%b fb_err=%b expected 1,0,0,0",
               gc.hist_clr, gc.turn, gc.busy, gc.fb_err);
    end
    gc.fb_valid = 1'b1;
    gc.fb_exact = 3'd4;
    cyc();
    gc.fb_valid = 1'b0;
    cyc();
    n_checks++;
    if ({gc.win, gc.mode, gc.turn} !== {1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL stale_fb_discarded: win=%b mode=%b turn=%0d expected 0,0,0", gc.win, gc.mode, gc.turn);
    end
  endtask

  task automatic test_timer();
    int s0;
    int exp_stores;
    logic [3:0] exp_turn;
`ifdef TURN_TIMER_EN
    exp_stores = 1;
    exp_turn   = 4'd1;
`else
    exp_stores = 0;
    exp_turn   = 4'd0;
`endif
    gc.btn_start = 1'b1;
    cyc();
    gc.btn_start = 1'b0;
    s0 = store_cnt;
    for (int i = 0; i < 3; i++) begin
      gc.tick = 1'b1;
      cyc();
      gc.tick = 1'b0;
      cyc();
    end
    cyc();
    n_checks++;
    if ((store_cnt - s0) !== exp_stores || gc.turn !== exp_turn) begin
      n_fail++;
      $display("FAIL turn_timer: stores=%0d turn=%0d expected %0d,%0d",
               store_cnt - s0, gc.turn, exp_stores, exp_turn);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    store_cnt     = 0;
    reset         = 1'b1;
    gc.btn_start  = 1'b0;
    gc.btn_submit = 1'b0;
    gc.btn_mode   = 1'b0;
    gc.tick       = 1'b0;
    gc.fb_valid   = 1'b0;
    gc.fb_exact   = 3'd0;
    test_reset();
    test_start();
    test_win();
    test_lose();
    test_timeout();
    test_hist();
    test_restart();
    test_timer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
